display_scanner: RTL and testbench

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_scanner.sv | 147 ++++++++++++++
 tb/tb_display_scanner.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : display_scanner
//  Description : Multiplexed 4-digit 7-segment hex display scanner with
//                frame-synchronous (tear-free) value update and optional
//                leading-zero blanking.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    Clk        in   1   sole clock, rising edge
//    Rst        in   1   synchronous active-high reset
//    Refresh    in   1   one-cycle strobe, advances the digit scan
//    Load       in   1   one-cycle request to capture Value/DpIn
//    Value      in  16   four hex nibbles, [3:0] = digit 0 (rightmost)
//    DpIn       in   4   per-digit decimal point, 1 = lit
//    Anode      out  4   active-low digit enables (one-hot low)
//    Seg        out  7   active-low segments {g,f,e,d,c,b,a}
//    Dp         out  1   active-low decimal point
//    Pending    out  1   captured value waiting for next frame boundary
//    FrameStart out  1   one-cycle pulse when the scan wraps to digit 0
// ============================================================================
module display_scanner #(
  parameter bit LZB = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Refresh,
  input  logic        Load,
  input  logic [15:0] Value,
  input  logic [3:0]  DpIn,
  output logic [3:0]  Anode,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic        Pending,
  output logic        FrameStart
);

  logic [1:0]  idx_q,  idx_d;
  logic [19:0] disp_q, disp_d;
  logic [19:0] pend_q, pend_d;
  logic        pend_valid_q, pend_valid_d;

  logic        wrap;
  logic [3:0]  nibble;
  logic        zero3, zero2, zero1;
  logic        blank;
  logic [6:0]  hex_seg;
  logic [6:0]  seg_d;
  logic [3:0]  anode_d;
  logic        dp_d;

  assign Pending = pend_valid_q;

  // Next-state: index, display and pending registers.
  always_comb begin
    wrap         = Refresh && (idx_q == 2'd3);
    idx_d        = Refresh ? idx_q + 2'd1 : idx_q;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    if (wrap) begin
      // Display register only ever changes here, so a frame is never torn.
      // A Load on this very edge bypasses and supersedes any queued value.
      pend_valid_d = 1'b0;
      if (Load) begin
        disp_d = {DpIn, Value};
      end else if (pend_valid_q) begin
        disp_d = pend_q;
      end
    end else if (Load) begin
      pend_d       = {DpIn, Value};
      pend_valid_d = 1'b1;
    end
  end

  // Segment data for the digit selected after this edge, taken from the
  // post-edge display contents so digit 0 shows a freshly swapped value.
  always_comb begin
    nibble = disp_d[{idx_d, 2'b00} +: 4];
    zero3  = (disp_d[15:12] == 4'd0);
    zero2  = zero3 && (disp_d[11:8] == 4'd0);
    zero1  = zero2 && (disp_d[7:4] == 4'd0);

    blank = 1'b0;
    if (LZB) begin
      case (idx_d)
        2'd3:    blank = zero3;
        2'd2:    blank = zero2;
        2'd1:    blank = zero1;
        default: blank = 1'b0;
      endcase
    end

    hex_seg = 7'b1111111;
    case (nibble)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      4'hF: hex_seg = 7'b0001110;
      default: hex_seg = 7'b1111111;
    endcase

    // A blanked digit still has its anode enabled and its DP honoured.
    seg_d   = blank ? 7'b1111111 : hex_seg;
    anode_d = ~(4'b0001 << idx_d);
    dp_d    = ~disp_d[5'd16 + {3'b000, idx_d}];
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      idx_q        <= 2'd3;
      disp_q       <= 20'd0;
      pend_q       <= 20'd0;
      pend_valid_q <= 1'b0;
      Anode        <= 4'b1111;
      Seg          <= 7'b1111111;
      Dp           <= 1'b1;
      FrameStart   <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      FrameStart   <= wrap;
      if (Refresh) begin
        Anode <= anode_d;
        Seg   <= seg_d;
        Dp    <= dp_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scanner
//  Description : Scoreboard bench for display_scanner. Stimulus pushes the
//                expected post-edge outputs for every Refresh edge; monitors
//                pop and compare on the following falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scanner;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sg;
    logic       dp;
    logic       fs;
    logic       pd;
  } exp_t;

  logic        clk;
  logic        Rst;
  logic        Refresh;
  logic        Load;
  logic [15:0] Value;
  logic [3:0]  DpIn;

  logic [3:0] an1, an0;
  logic [6:0] sg1, sg0;
  logic       dp1, dp0, pd1, pd0, fs1, fs0;

  int checks   = 0;
  int failures = 0;

  exp_t q1[$];
  exp_t q0[$];
  logic refresh_d = 1'b0;

  display_scanner #(.LZB(1'b1)) dut1 (
    .Clk(clk), .Rst(Rst), .Refresh(Refresh), .Load(Load), .Value(Value),
    .DpIn(DpIn), .Anode(an1), .Seg(sg1), .Dp(dp1), .Pending(pd1),
    .FrameStart(fs1)
  );

  display_scanner #(.LZB(1'b0)) dut0 (
    .Clk(clk), .Rst(Rst), .Refresh(Refresh), .Load(Load), .Value(Value),
    .DpIn(DpIn), .Anode(an0), .Seg(sg0), .Dp(dp0), .Pending(pd0),
    .FrameStart(fs0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push1(input logic [3:0] an, input logic [6:0] sg, input logic dp,
                       input logic fs, input logic pd);
    exp_t e;
    e.an = an; e.sg = sg; e.dp = dp; e.fs = fs; e.pd = pd;
    q1.push_back(e);
  endtask

  task automatic push0(input logic [3:0] an, input logic [6:0] sg, input logic dp,
                       input logic fs, input logic pd);
    exp_t e;
    e.an = an; e.sg = sg; e.dp = dp; e.fs = fs; e.pd = pd;
    q0.push_back(e);
  endtask

  // One clock edge with the given inputs; returns 2 time units after the edge.
  task automatic step(input logic r, input logic l, input logic [15:0] v, input logic [3:0] d);
    Refresh = r; Load = l; Value = v; DpIn = d;
    @(posedge clk);
    #2;
    Refresh = 1'b0; Load = 1'b0;
  endtask

  always @(posedge clk) refresh_d <= Refresh;

  // Monitor for the blanking-enabled instance: every Refresh edge is checked.
  always @(negedge clk) begin
    if (refresh_d) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon1_underflow: unexpected Refresh output at %0t", $time);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("mon1_anode",   32'(an1), 32'(e.an));
        chk("mon1_seg",     32'(sg1), 32'(e.sg));
        chk("mon1_dp",      32'(dp1), 32'(e.dp));
        chk("mon1_frame",   32'(fs1), 32'(e.fs));
        chk("mon1_pending", 32'(pd1), 32'(e.pd));
      end
    end
  end

  // Monitor for the non-blanking instance: only checked where queued.
  always @(negedge clk) begin
    if (refresh_d && q0.size() != 0) begin
      exp_t e;
      e = q0.pop_front();
      chk("mon0_anode", 32'(an0), 32'(e.an));
      chk("mon0_seg",   32'(sg0), 32'(e.sg));
      chk("mon0_dp",    32'(dp0), 32'(e.dp));
      chk("mon0_frame", 32'(fs0), 32'(e.fs));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; Refresh = 1'b0; Load = 1'b0; Value = 16'h0; DpIn = 4'h0;
    repeat (2) @(posedge clk);
    #2;
    Rst = 1'b0;

    // Reset state holds with no Refresh.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      chk("rst_anode",   32'(an1), 32'h0000000F);
      chk("rst_seg",     32'(sg1), 32'h0000007F);
      chk("rst_dp",      32'(dp1), 32'h1);
      chk("rst_pending", 32'(pd1), 32'h0);
      chk("rst_frame",   32'(fs1), 32'h0);
    end

    // 12AF with DP on digit 2, one Refresh per two cycles.
    step(1'b0, 1'b1, 16'h12AF, 4'b0100);
    chk("load_pending", 32'(pd1), 32'h1);
    push1(4'b1110, 7'b0001110, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    chk("hold_frame", 32'(fs1), 32'h0);
    chk("hold_anode", 32'(an1), 32'hE);
    chk("hold_seg",   32'(sg1), 32'(7'b0001110));
    push1(4'b1101, 7'b0001000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    push1(4'b1011, 7'b0100100, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    push1(4'b0111, 7'b1111001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 4'h0);

    // Mid-frame load must not tear the current frame.
    push1(4'b1110, 7'b0001110, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    push1(4'b1101, 7'b0001000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b1, 16'h8888, 4'b0000);
    chk("midframe_pending", 32'(pd1), 32'h1);
    push1(4'b1011, 7'b0100100, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    push1(4'b0111, 7'b1111001, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    push1(4'b1110, 7'b0000000, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    push1(4'b1101, 7'b0000000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    push1(4'b1011, 7'b0000000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    push1(4'b0111, 7'b0000000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);

    // Load on the wrap edge goes straight to digit 0.
    push1(4'b1110, 7'b0000010, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h3456, 4'b0001);
    push1(4'b1101, 7'b0010010, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    // Two loads in one frame: the second wins.
    step(1'b0, 1'b1, 16'h1111, 4'b0000);
    chk("twoload_pending", 32'(pd1), 32'h1);
    step(1'b0, 1'b1, 16'h0040, 4'b1000);
    push1(4'b1011, 7'b0011001, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    push1(4'b0111, 7'b0110000, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    // 0040 with leading-zero blanking; blanked digit 3 keeps its DP.
    push1(4'b1110, 7'b1000000, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    push1(4'b1101, 7'b0011001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    push1(4'b1011, 7'b1111111, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    push1(4'b0111, 7'b1111111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);

    // Value 0 with Refresh every cycle, both blanking settings.
    step(1'b0, 1'b1, 16'h0000, 4'b0000);
    chk("zero_pending", 32'(pd1), 32'h1);
    push1(4'b1110, 7'b1000000, 1'b1, 1'b1, 1'b0);
    push1(4'b1101, 7'b1111111, 1'b1, 1'b0, 1'b0);
    push1(4'b1011, 7'b1111111, 1'b1, 1'b0, 1'b0);
    push1(4'b0111, 7'b1111111, 1'b1, 1'b0, 1'b0);
    push0(4'b1110, 7'b1000000, 1'b1, 1'b1, 1'b0);
    push0(4'b1101, 7'b1000000, 1'b1, 1'b0, 1'b0);
    push0(4'b1011, 7'b1000000, 1'b1, 1'b0, 1'b0);
    push0(4'b0111, 7'b1000000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0, 4'h0);

    // Reset with Pending=1 and Refresh/Load active: reset wins, Pend dropped.
    push1(4'b1110, 7'b1000000, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b1, 16'hFFFF, 4'b1111);
    chk("prerst_pending", 32'(pd1), 32'h1);
    Rst = 1'b1;
    push1(4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'hAAAA, 4'b1111);
    Rst = 1'b0;
    chk("midrst_anode",   32'(an1), 32'hF);
    chk("midrst_pending", 32'(pd1), 32'h0);
    push1(4'b1110, 7'b1000000, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b0, 16'h0, 4'h0);

    chk("q1_drained", 32'(q1.size()), 32'h0);
    chk("q0_drained", 32'(q0.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
